// File: rtl/reg_nx1_mux.sv
// N:1 WIDTH-bit registered mux with valid/ready handshake and a 2-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining MUX_SELERR_EN.
module reg_nx1_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  // S_EMPTY: nothing held | S_ONE: output reg full | S_TWO: output reg and skid full
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_sel;
  logic [WIDTH-1:0]   r_skid_data;
  logic [SEL_W-1:0]   r_skid_sel;

  logic [WIDTH-1:0]   w_sel_data;
  logic               w_accept;
  logic               w_drain;
  logic               w_load_out_in;
  logic               w_load_out_skid;
  logic               w_load_skid;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // Unmatched select codes (only possible for non-power-of-2 N) yield all-zero data
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_accept && !w_drain)      w_state_nxt = S_TWO;
        else if (!w_accept && w_drain) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_drain) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: w_load_out_in = w_accept;
      S_ONE: begin
        w_load_out_in = w_accept & w_drain;
        w_load_skid   = w_accept & ~w_drain;
      end
      S_TWO:   w_load_out_skid = w_drain;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out_data <= w_sel_data;
        r_out_sel  <= sel;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
        r_out_sel  <= r_skid_sel;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_sel  <= sel;
      end else if (w_load_out_skid) begin
        r_skid_data <= '0;
        r_skid_sel  <= '0;
      end
    end
  end

`ifdef MUX_SELERR_EN
  logic w_sel_hit;
  logic r_sel_err;

  always_comb begin
    w_sel_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) w_sel_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_sel_err <= 1'b0;
    else if (w_accept && !w_sel_hit) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
